// File: rtl/cpu_types_pkg.sv
// Shared types for the multicore memory path: word, RAM handshake state,
// arbiter FSM state and the default grant timeout.
package cpu_types_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned ARB_TIMEOUT = 1023;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = IW'((32'(ptr) + off) % N);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port among per-core I and D ports: D beats I, round-robin
// within a class, one registered owner per transaction with abort/timeout.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned CPUS    = 2,
  parameter int unsigned TIMEOUT = ARB_TIMEOUT,
  localparam int unsigned OW = (CPUS > 1) ? $clog2(2 * CPUS) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [CPUS-1:0]       iREN,
  input  logic [CPUS-1:0][31:0] iaddr,
  output logic [CPUS-1:0]       iwait,
  output logic [CPUS-1:0][31:0] iload,
  input  logic [CPUS-1:0]       dREN,
  input  logic [CPUS-1:0]       dWEN,
  input  logic [CPUS-1:0][31:0] daddr,
  input  logic [CPUS-1:0][31:0] dstore,
  output logic [CPUS-1:0]       dwait,
  output logic [CPUS-1:0][31:0] dload,
  output logic                  ramREN,
  output logic                  ramWEN,
  output logic [31:0]           ramaddr,
  output logic [31:0]           ramstore,
  input  logic [31:0]           ramload,
  input  logic [1:0]            ramstate,
  output logic                  busy,
  output logic [OW-1:0]         owner,
  output logic                  timeout_err
);

  localparam int unsigned PW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  arb_state_t    state, state_nx;
  logic [OW-1:0] owner_nx;
  logic [PW-1:0] dptr, dptr_nx, iptr, iptr_nx;
  logic [CW-1:0] tmr, tmr_nx;
  logic          terr_nx;

  logic          d_valid, i_valid;
  logic [PW-1:0] d_idx, i_idx;
  logic          own_is_d, live;
  logic [PW-1:0] own_idx, own_inc;

  rr_arbiter #(.N(CPUS)) u_rr_d (
    .req       (dREN | dWEN),
    .ptr       (dptr),
    .gnt_valid (d_valid),
    .gnt_idx   (d_idx)
  );

  rr_arbiter #(.N(CPUS)) u_rr_i (
    .req       (iREN),
    .ptr       (iptr),
    .gnt_valid (i_valid),
    .gnt_idx   (i_idx)
  );

  // Owner encoding: D ports first, then I ports offset by CPUS.
  assign own_is_d = (owner < OW'(CPUS));
  assign own_idx  = own_is_d ? PW'(owner) : PW'(owner - OW'(CPUS));
  assign own_inc  = (own_idx == PW'(CPUS - 1)) ? '0 : own_idx + PW'(1);
  assign busy     = (state != IDLE);

  always_comb begin
    for (int i = 0; i < int'(CPUS); i++) begin
      iload[i] = ramload;
      dload[i] = ramload;
    end
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    dptr_nx  = dptr;
    iptr_nx  = iptr;
    tmr_nx   = tmr;
    terr_nx  = timeout_err;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    live     = 1'b0;

    case (state)
      IDLE: begin
        if (d_valid) begin
          owner_nx = OW'(d_idx);
          tmr_nx   = '0;
          state_nx = GRANT;
        end else if (i_valid) begin
          owner_nx = OW'(CPUS) + OW'(i_idx);
          tmr_nx   = '0;
          state_nx = GRANT;
        end
      end

      GRANT: begin
        if (own_is_d) begin
          ramWEN   = dWEN[own_idx];
          ramREN   = dREN[own_idx] & ~dWEN[own_idx];
          ramaddr  = daddr[own_idx];
          ramstore = dstore[own_idx];
          live     = dREN[own_idx] | dWEN[own_idx];
        end else begin
          ramREN   = iREN[own_idx];
          ramaddr  = iaddr[own_idx];
          live     = iREN[own_idx];
        end

        // Completion takes precedence over drop, error and timeout.
        if (ramstate == ACCESS) begin
          if (own_is_d) begin
            dwait[own_idx] = 1'b0;
            dptr_nx        = own_inc;
          end else begin
            iwait[own_idx] = 1'b0;
            iptr_nx        = own_inc;
          end
          state_nx = IDLE;
        end else if (!live || ramstate == ERROR) begin
          state_nx = ABORT;
        end else if (tmr + CW'(1) == CW'(TIMEOUT)) begin
          terr_nx  = 1'b1;
          state_nx = ABORT;
        end else begin
          tmr_nx = tmr + CW'(1);
        end
      end

      ABORT:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      owner       <= '0;
      dptr        <= '0;
      iptr        <= '0;
      tmr         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      owner       <= owner_nx;
      dptr        <= dptr_nx;
      iptr        <= iptr_nx;
      tmr         <= tmr_nx;
      timeout_err <= terr_nx;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: reset, priority, fairness, abort, error,
// timeout and mid-transaction reset, all against hand-computed values.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned CPUS = 2;

  logic             CLK, RST;
  logic [1:0]       iREN, iwait, dREN, dWEN, dwait;
  logic [1:0][31:0] iaddr, iload, daddr, dstore, dload;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  logic [1:0]       ramstate;
  logic             busy;
  logic [1:0]       owner;
  logic             timeout_err;

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.CPUS(CPUS), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .busy(busy), .owner(owner), .timeout_err(timeout_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  initial begin
    RST = 1'b1; iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;
    repeat (2) @(negedge CLK);

    // Reset state, then single I fetch from core0 completing at cycle 3
    RST = 1'b0; iREN = 2'b01; iaddr[0] = 32'h40; #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_owner", 32'(owner), 0);
    check("rst_ramren", 32'(ramREN), 0);
    check("rst_iwait", 32'(iwait), 3);
    check("rst_dwait", 32'(dwait), 3);
    check("rst_terr", 32'(timeout_err), 0);
    @(negedge CLK); ramstate = BUSY; #1;
    check("t1_c1_ramren", 32'(ramREN), 1);
    check("t1_c1_addr", ramaddr, 32'h40);
    check("t1_c1_owner", 32'(owner), 2);
    check("t1_c1_busy", 32'(busy), 1);
    check("t1_c1_iwait", 32'(iwait), 3);
    @(negedge CLK); #1;
    check("t1_c2_iwait", 32'(iwait), 3);
    @(negedge CLK); ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
    check("t1_c3_iwait", 32'(iwait), 2);
    check("t1_c3_iload0", iload[0], 32'hDEADBEEF);
    check("t1_c3_dload1", dload[1], 32'hDEADBEEF);
    @(negedge CLK); ramstate = FREE; iREN = '0; #1;
    check("t1_c4_busy", 32'(busy), 0);
    check("t1_c4_iwait", 32'(iwait), 3);

    // D write beats same-cycle I fetch; fetch served in next grant
    @(negedge CLK);
    iREN = 2'b01; iaddr[0] = 32'h44;
    dWEN = 2'b10; daddr[1] = 32'h80; dstore[1] = 32'h1234; #1;
    check("t2_idle_busy", 32'(busy), 0);
    @(negedge CLK); ramstate = ACCESS; #1;
    check("t2_owner_d", 32'(owner), 1);
    check("t2_ramwen", 32'(ramWEN), 1);
    check("t2_ramren", 32'(ramREN), 0);
    check("t2_store", ramstore, 32'h1234);
    check("t2_addr", ramaddr, 32'h80);
    check("t2_dwait", 32'(dwait), 1);
    check("t2_iwait", 32'(iwait), 3);
    @(negedge CLK); dWEN = '0; ramstate = FREE; #1;
    check("t2_gap_busy", 32'(busy), 0);
    @(negedge CLK); ramstate = ACCESS; #1;
    check("t2_owner_i", 32'(owner), 2);
    check("t2_i_addr", ramaddr, 32'h44);
    check("t2_i_iwait", 32'(iwait), 2);
    @(negedge CLK); iREN = '0; ramstate = FREE; #1;
    check("t2_end_busy", 32'(busy), 0);

    // Round-robin among D reads held continuously, ACCESS latency 2
    daddr[0] = 32'h100; daddr[1] = 32'h200;
    for (int t = 0; t < 5; t++) begin
      @(negedge CLK); ramstate = FREE; dREN = 2'b11; #1;
      check("t3_idle", 32'(busy), 0);
      @(negedge CLK); ramstate = BUSY; #1;
      check("t3_owner", 32'(owner), 32'(t % 2));
      check("t3_addr", ramaddr, (t % 2 == 1) ? 32'h200 : 32'h100);
      check("t3_ramren", 32'(ramREN), 1);
      @(negedge CLK); ramstate = ACCESS; #1;
      check("t3_dwait", 32'(dwait), (t % 2 == 1) ? 32'd1 : 32'd2);
    end
    @(negedge CLK); ramstate = FREE; dREN = '0; #1;
    check("t3_end_busy", 32'(busy), 0);

    // Core1 D read dropped before ACCESS: abort, pointer stays on core1
    @(negedge CLK); dREN = 2'b10; daddr[1] = 32'h300; #1;
    check("t4_idle", 32'(busy), 0);
    @(negedge CLK); ramstate = BUSY; #1;
    check("t4_owner", 32'(owner), 1);
    check("t4_ramren", 32'(ramREN), 1);
    @(negedge CLK); dREN = '0; #1;
    check("t4_drop_ramren", 32'(ramREN), 0);
    check("t4_drop_dwait", 32'(dwait), 3);
    @(negedge CLK); #1;
    check("t4_abort_busy", 32'(busy), 1);
    check("t4_abort_ramren", 32'(ramREN), 0);
    check("t4_abort_dwait", 32'(dwait), 3);
    @(negedge CLK); ramstate = FREE; dREN = 2'b11; #1;
    check("t4_idle2", 32'(busy), 0);
    @(negedge CLK); ramstate = ACCESS; #1;
    check("t4_ptr_kept", 32'(owner), 1);
    check("t4_dwait", 32'(dwait), 1);
    @(negedge CLK); ramstate = FREE; dREN = '0; #1;
    check("t4_end_busy", 32'(busy), 0);

    // ERROR in GRANT aborts without flagging a timeout
    @(negedge CLK); dREN = 2'b01; daddr[0] = 32'h600; #1;
    check("t5_idle", 32'(busy), 0);
    @(negedge CLK); ramstate = ERROR; #1;
    check("t5_owner", 32'(owner), 0);
    check("t5_dwait", 32'(dwait), 3);
    @(negedge CLK); ramstate = FREE; dREN = '0; #1;
    check("t5_abort_busy", 32'(busy), 1);
    check("t5_abort_ramren", 32'(ramREN), 0);
    check("t5_terr", 32'(timeout_err), 0);
    @(negedge CLK); #1;
    check("t5_end_busy", 32'(busy), 0);

    // Timeout after 8 GRANT cycles of BUSY; flag sticks, retry served
    @(negedge CLK); iREN = 2'b10; iaddr[1] = 32'h500; #1;
    check("t6_idle", 32'(busy), 0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK); ramstate = BUSY; #1;
      check("t6_ramren", 32'(ramREN), 1);
      if (k == 1) check("t6_owner", 32'(owner), 3);
      if (k == 8) check("t6_terr_pre", 32'(timeout_err), 0);
    end
    @(negedge CLK); #1;
    check("t6_terr_set", 32'(timeout_err), 1);
    check("t6_abort_ramren", 32'(ramREN), 0);
    check("t6_abort_busy", 32'(busy), 1);
    check("t6_abort_iwait", 32'(iwait), 3);
    @(negedge CLK); ramstate = FREE; #1;
    check("t6_idle2", 32'(busy), 0);
    @(negedge CLK); ramstate = ACCESS; #1;
    check("t6_retry_owner", 32'(owner), 3);
    check("t6_retry_iwait", 32'(iwait), 1);
    check("t6_terr_sticky", 32'(timeout_err), 1);
    @(negedge CLK); ramstate = FREE; iREN = '0; #1;
    check("t6_end_busy", 32'(busy), 0);

    // Advance I pointer to core1, then reset mid-write
    @(negedge CLK); iREN = 2'b01; iaddr[0] = 32'h40; #1;
    @(negedge CLK); ramstate = ACCESS; #1;
    check("t7_pre_iwait", 32'(iwait), 2);
    @(negedge CLK); ramstate = FREE; iREN = '0;
    dWEN = 2'b01; daddr[0] = 32'h700; dstore[0] = 32'h55; #1;
    check("t7_idle", 32'(busy), 0);
    @(negedge CLK); ramstate = BUSY; RST = 1'b1; #1;
    check("t7_ramwen", 32'(ramWEN), 1);
    check("t7_store", ramstore, 32'h55);
    @(negedge CLK); RST = 1'b0; dWEN = '0; iREN = 2'b11; ramstate = FREE; #1;
    check("t7_rst_ramren", 32'(ramREN), 0);
    check("t7_rst_ramwen", 32'(ramWEN), 0);
    check("t7_rst_iwait", 32'(iwait), 3);
    check("t7_rst_dwait", 32'(dwait), 3);
    check("t7_rst_busy", 32'(busy), 0);
    check("t7_rst_owner", 32'(owner), 0);
    check("t7_rst_terr", 32'(timeout_err), 0);
    @(negedge CLK); ramstate = ACCESS; #1;
    check("t7_ptr_reset", 32'(owner), 2);
    check("t7_addr", ramaddr, 32'h40);
    check("t7_iwait", 32'(iwait), 2);
    @(negedge CLK); ramstate = FREE; iREN = '0; #1;
    check("t7_end_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Multicore RAM arbiter: shares the single RAM port among CPUS instruction fetchers and CPUS data ports.
- Registers a single owner per RAM transaction and holds RAM control/address stable until ramstate reports ACCESS.
- Returns wait/load to the owner only.
- Sits between the per-CPU cache ports and the RAM model; coherence signalling stays in a separate block.

Parameters:
- CPUS, 2, number of cores; each core has one I port and one D port.
- TIMEOUT, 1023, cycles a granted transaction may wait for ACCESS before abort.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- iREN  in  CPUS  instruction read request per core
- iaddr  in  CPUS x 32  instruction address per core
- iwait  out  CPUS  low for exactly the cycle the core's I read completes
- iload  out  CPUS x 32  ramload, fanned out to every core
- dREN, dWEN  in  CPUS each  data read / write request per core
- daddr, dstore  in  CPUS x 32 each  data address / write data per core
- dwait  out  CPUS  low for exactly the cycle the core's D access completes
- dload  out  CPUS x 32  ramload, fanned out to every core
- ramREN, ramWEN  out  1 each  RAM read / write strobe
- ramaddr, ramstore  out  32 each  RAM address / write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- busy  out  1  transaction in flight
- owner  out  $clog2(2*CPUS)  current grant index; D ports 0..CPUS-1, I ports CPUS..2*CPUS-1
- timeout_err  out  1  sticky; cleared only by RST

Behaviour:
- One clock CLK; reset RST is synchronous and active-high.
- Reset values: state IDLE, ramREN=ramWEN=0, ramaddr=ramstore=0, all iwait/dwait=1, busy=0, owner=0, timeout_err=0, both round-robin pointers=0, timeout counter=0.
- States:
  - IDLE: no grant.
  - GRANT: ram* outputs driven from latched owner.
  - ABORT: one cycle, ram strobes forced 0.
- IDLE transitions:
  - No request: remain in IDLE.
  - Any request: register the winner into owner, go to GRANT next edge.
  - Arbitration: any D request beats every I request.
  - Within a class: round-robin starting at that class's pointer.
- GRANT output rules:
  - ramWEN = owner's dWEN.
  - ramREN = owner's dREN & ~dWEN for a D owner, or owner's iREN for an I owner.
  - dREN and dWEN both high: treated as a write.
  - ramaddr/ramstore come from the owner's live inputs; requesters hold them stable while waiting.
- Completion:
  - Owner's wait = ~(ramstate==ACCESS), combinational, only in GRANT; all other waits stay 1.
  - On ACCESS: advance that class's pointer to owner+1 mod CPUS, return to IDLE.
  - Minimum spacing between grants is two cycles: grant cycle, then IDLE arbitration cycle.
- Latency: request in IDLE at cycle 0 -> ram strobe at cycle 1 -> wait low in the first cycle ≥1 where ramstate==ACCESS.
- Owner request drops in GRANT before ACCESS: go to ABORT, no wait pulse, pointer not advanced, then IDLE.
- Error and timeout:
  - ramstate==ERROR in GRANT: same as a drop (ABORT), and timeout_err is not set.
  - Counter resets on grant and increments each GRANT cycle without ACCESS.
  - At TIMEOUT: set timeout_err, go to ABORT.
- Same-cycle events:
  - ACCESS coincident with a request drop: completion wins (wait pulse issued).
  - ACCESS coincident with TIMEOUT: completion wins.
- Non-owner requests during GRANT: ignored and not queued; arbitration re-evaluates in IDLE.
- RST mid-transaction: immediate return to IDLE next edge, strobes 0, no wait pulse.
- iload/dload = ramload unconditionally.

Decomposition:
- cpu_types_pkg holds:
  - word_t (32 bits)
  - ramstate_t
  - new arb_state_t {IDLE, GRANT, ABORT}
  - ARB_TIMEOUT default
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req[N], ptr.
  - Outputs: gnt_valid, gnt_idx.
  - Purely combinational, instantiated twice (D class, I class).
- Pointers and FSM live in ram_arbiter.

Test Plan:
- Reset then single request: RST high 2 cycles, then core0 iREN=1, iaddr=0x40; RAM asserts ACCESS at cycle 3 with ramload=0xDEADBEEF -> ramREN=1 and ramaddr=0x40 from cycle 1; iwait[0]=0 only in cycle 3; iload[0]=0xDEADBEEF; busy 1→0.
- D over I priority: core0 iREN and core1 dWEN (daddr=0x80, dstore=0x1234) asserted the same cycle -> owner=1, ramWEN=1, ramstore=0x1234 first; the core0 fetch is served in the next grant.
- Round-robin fairness: both cores hold dREN continuously, fixed ACCESS latency 2 -> grants alternate 0,1,0,1 over 4 transactions; no core served twice in a row.
- Abort on drop: core1 dREN granted, deasserted before ACCESS -> ABORT for one cycle with ram strobes 0; dwait[1] never low; D pointer unchanged.
- Timeout: TIMEOUT=8, ramstate held BUSY -> after 8 GRANT cycles timeout_err=1 (sticky) and ABORT; the next request is still served normally with timeout_err still 1.
- Reset mid-transaction: RST asserted while in GRANT -> next cycle ramREN=ramWEN=0, all waits=1, busy=0, owner=0, pointers=0.
